// File: rtl/lsu_data_mem_if.sv
// -----------------------------------------------------------------------------
// lsu_data_mem_if
// Load/store bus between the RV32 core's LSU and the data memory.
//   i_req       access request this cycle
//   i_wren      1 = store, 0 = load
//   i_size      00 byte, 01 halfword, 1x word
//   i_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   i_addr      byte address
//   i_wdata     right-aligned store data
//   o_rdata     extended load data (valid with o_ready on a load)
//   o_ready     access completes this cycle
//   o_stall     core must hold every request signal stable next cycle
//   o_err       access out of range
// modport master: the core side; modport slave: the memory side.
// -----------------------------------------------------------------------------
interface lsu_data_mem_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              i_req;
   logic              i_wren;
   logic [1:0]        i_size;
   logic              i_unsigned;
   logic [ADDR_W-1:0] i_addr;
   logic [31:0]       i_wdata;
   logic [31:0]       o_rdata;
   logic              o_ready;
   logic              o_stall;
   logic              o_err;

   modport master (
      output i_req, i_wren, i_size, i_unsigned, i_addr, i_wdata,
      input  o_rdata, o_ready, o_stall, o_err
   );

   modport slave (
      input  i_req, i_wren, i_size, i_unsigned, i_addr, i_wdata,
      output o_rdata, o_ready, o_stall, o_err
   );
endinterface

// File: rtl/lsu_data_mem.sv
// -----------------------------------------------------------------------------
// lsu_data_mem
// Byte-addressable little-endian data memory for the RV32 load/store path.
// Byte, halfword and word accesses with sign/zero extension on loads, a
// configurable address window with range-error reporting, and a two-state
// FSM that splits accesses crossing a word boundary into two cycles.
//
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-low reset (clears FSM and hold register only)
//   bus     lsu_data_mem_if.slave request/response bundle
//
// Loads are answered combinationally in the request cycle; stores commit at
// the next rising edge. A crossing access stalls for one cycle: the first
// cycle handles bytes offset..3 of word W, the second handles the rest in
// word W+1.
// -----------------------------------------------------------------------------
module lsu_data_mem #(
   parameter int unsigned       ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h2000,
   parameter int unsigned       DEPTH_WORDS = 2048
) (
   input logic           i_clk,
   input logic           i_rst,
   lsu_data_mem_if.slave bus
);

   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [31:0] BASE32 = 32'(BASE_ADDR);
   localparam logic [31:0] TOP32  = BASE32 + 32'(DEPTH_WORDS) * 32'd4;

   typedef enum logic {IDLE, SECOND} state_t;

   state_t      state;
   logic [31:0] hold;

   logic [3:0][7:0] mem [DEPTH_WORDS];

   logic [31:0]      addr32;
   logic [31:0]      last32;
   logic [1:0]       off;
   logic [2:0]       nbytes;
   logic [7:0]       mask_base;
   logic [7:0]       lane_mask;
   logic [63:0]      wdata_sh;
   logic             in_range;
   logic             crossing;
   logic [IDX_W-1:0] widx;
   logic [IDX_W-1:0] widx_nxt;
   logic [IDX_W-1:0] rd_idx;
   logic [31:0]      rd_word;
   logic [31:0]      ld_raw;
   logic [31:0]      ld_ext;

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [3:0]       wr_mask;
   logic [3:0][7:0]  wr_data;

   // Address decode. Both halves of a crossing access are described in one
   // 8-byte view (word W in the low half, word W+1 in the high half).
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      addr32 = 32'(bus.i_addr);
      off    = bus.i_addr[1:0];
      case (bus.i_size)
         2'b00:   begin nbytes = 3'd1; mask_base = 8'h01; end
         2'b01:   begin nbytes = 3'd2; mask_base = 8'h03; end
         default: begin nbytes = 3'd4; mask_base = 8'h0F; end
      endcase
      last32    = addr32 + 32'(nbytes) - 32'd1;
      in_range  = (addr32 >= BASE32) && (last32 < TOP32);
      crossing  = (3'(off) + nbytes) > 3'd4;
      widx      = IDX_W'((addr32 - BASE32) >> 2);
      widx_nxt  = widx + IDX_W'(1);
      lane_mask = mask_base << off;
      wdata_sh  = {32'b0, bus.i_wdata} << {off, 3'b000};
   end

   // Single combinational read port: word W in IDLE, word W+1 in SECOND.
   assign rd_idx  = (state == SECOND) ? widx_nxt : widx;
   assign rd_word = mem[rd_idx];

   // In SECOND the low bytes come from the hold register captured last cycle.
   always_comb begin
      if (state == SECOND) begin
         ld_raw = 32'({rd_word, hold} >> {off, 3'b000});
      end else begin
         ld_raw = rd_word >> {off, 3'b000};
      end
      case (bus.i_size)
         2'b00:   ld_ext = {{24{~bus.i_unsigned & ld_raw[7]}},  ld_raw[7:0]};
         2'b01:   ld_ext = {{16{~bus.i_unsigned & ld_raw[15]}}, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
   end

   // Write port selection. SECOND completes the upper part even if i_req
   // drops; reset blocks any write so an aborted access leaves only its
   // first half behind.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = widx;
      wr_mask = lane_mask[3:0];
      wr_data = wdata_sh[31:0];
      if (i_rst && bus.i_wren) begin
         if (state == IDLE) begin
            wr_en = bus.i_req && in_range;
         end else begin
            wr_en   = 1'b1;
            wr_idx  = widx_nxt;
            wr_mask = lane_mask[7:4];
            wr_data = wdata_sh[63:32];
         end
      end
   end

   // NOTE: the storage array has no reset; its contents survive i_rst and it can map to RAM.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) mem[wr_idx][b] <= wr_data[b];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= IDLE;
         hold  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_req && in_range && crossing) begin
                  state <= SECOND;
                  hold  <= rd_word;
               end
            end
            SECOND:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Responses are same-cycle; reset forces them low without waiting for a clock.
   always_comb begin
      bus.o_ready = 1'b0;
      bus.o_stall = 1'b0;
      bus.o_err   = 1'b0;
      bus.o_rdata = '0;
      if (i_rst) begin
         if (state == SECOND) begin
            bus.o_ready = 1'b1;
            bus.o_rdata = bus.i_wren ? 32'd0 : ld_ext;
         end else if (bus.i_req) begin
            if (!in_range) begin
               bus.o_err   = 1'b1;
               bus.o_ready = 1'b1;
            end else if (crossing) begin
               bus.o_stall = 1'b1;
            end else begin
               bus.o_ready = 1'b1;
               bus.o_rdata = bus.i_wren ? 32'd0 : ld_ext;
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu_data_mem.sv
// -----------------------------------------------------------------------------
// tb_lsu_data_mem
// Scoreboard bench for lsu_data_mem. The driver computes each access's
// expected response from a byte-array reference model and queues it; a
// monitor on the falling edge pops and compares whenever o_ready is high,
// and also counts the stall cycles that preceded it. A second instance
// with a different window covers the parameter build.
// -----------------------------------------------------------------------------
module tb_lsu_data_mem;

   localparam int BASE  = 'h2000;
   localparam int DEPTH = 2048;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        is_load;
      int          stalls;
      logic [15:0] addr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lsu_data_mem_if #(.ADDR_W(16)) bus ();
   lsu_data_mem_if #(.ADDR_W(16)) bus2 ();

   lsu_data_mem #(.ADDR_W(16), .BASE_ADDR(16'h2000), .DEPTH_WORDS(2048)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   lsu_data_mem #(.ADDR_W(16), .BASE_ADDR(16'h4000), .DEPTH_WORDS(256)) dut2 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus2)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   logic [7:0] ref_mem [0:4*DEPTH-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
   endtask

   // Reference model: memory is a flat byte array indexed from the window base.
   function automatic exp_t model(input logic [15:0] a, input logic [1:0] sz,
                                  input logic wr, input logic uns, input logic [31:0] wd);
      exp_t e;
      int   nb;
      int   lo;
      nb        = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      lo        = int'(a) - BASE;
      e.addr    = a;
      e.is_load = !wr;
      e.rdata   = 32'd0;
      e.err     = (lo < 0) || (lo + nb > 4 * DEPTH);
      e.stalls  = (!e.err && ((int'(a) % 4) + nb > 4)) ? 1 : 0;
      if (!e.err) begin
         if (wr) begin
            for (int i = 0; i < nb; i++) ref_mem[lo + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < nb; i++) e.rdata[8*i +: 8] = ref_mem[lo + i];
            if (!uns && nb < 4 && e.rdata[8*nb-1]) begin
               for (int i = nb; i < 4; i++) e.rdata[8*i +: 8] = 8'hFF;
            end
         end
      end
      return e;
   endfunction

   // Issue one access and hold it until the DUT reports completion.
   task automatic access(input logic [15:0] a, input logic [1:0] sz, input logic wr,
                         input logic uns, input logic [31:0] wd);
      int cyc;
      sb.push_back(model(a, sz, wr, uns, wd));
      bus.i_addr     = a;
      bus.i_size     = sz;
      bus.i_wren     = wr;
      bus.i_unsigned = uns;
      bus.i_wdata    = wd;
      bus.i_req      = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.o_ready && cyc < 8);
      if (!bus.o_ready) begin
         check("ready_timeout", 32'(bus.o_ready), 32'd1);
         sb.delete();
      end
      @(posedge clk);
      #1;
      bus.i_req = 1'b0;
   endtask

   // Monitor: compares every completed access against the queued expectation.
   int stall_cnt = 0;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         stall_cnt = 0;
      end else if (bus.o_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_ready", 32'(bus.o_ready), 32'd0);
         end else begin
            e = sb.pop_front();
            check($sformatf("err@%04h", e.addr), 32'(bus.o_err), 32'(e.err));
            check($sformatf("stall_cycles@%04h", e.addr), 32'(stall_cnt), 32'(e.stalls));
            if (e.is_load || e.err)
               check($sformatf("rdata@%04h", e.addr), bus.o_rdata, e.rdata);
         end
         stall_cnt = 0;
      end else if (bus.o_stall) begin
         stall_cnt++;
      end
   end

   logic [15:0] ra;
   int          rsel;

   initial begin
      for (int i = 0; i < 4 * DEPTH; i++) ref_mem[i] = 8'h00;
      bus2.i_req = 1'b0; bus2.i_wren = 1'b0; bus2.i_size = 2'b10;
      bus2.i_unsigned = 1'b0; bus2.i_addr = 16'h4000; bus2.i_wdata = 32'd0;

      // Reset: outputs must be 0 even with a request pending.
      bus.i_req = 1'b1; bus.i_wren = 1'b0; bus.i_size = 2'b10;
      bus.i_unsigned = 1'b0; bus.i_addr = 16'h2000; bus.i_wdata = 32'd0;
      #12;
      check("rst_ready", 32'(bus.o_ready), 32'd0);
      check("rst_stall", 32'(bus.o_stall), 32'd0);
      check("rst_err",   32'(bus.o_err),   32'd0);
      check("rst_rdata", bus.o_rdata,      32'd0);
      bus.i_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(bus.o_ready), 32'd0);
      check("idle_stall", 32'(bus.o_stall), 32'd0);
      check("idle_err",   32'(bus.o_err),   32'd0);
      @(posedge clk);
      #1;

      // Memory contents are not reset: zero the whole window first.
      for (int w = 0; w < DEPTH; w++) access(16'(BASE + 4 * w), 2'b10, 1'b1, 1'b0, 32'd0);

      // Aligned word, then byte/half views and a byte store.
      access(16'h2000, 2'b10, 1'b1, 1'b0, 32'hDEADBEEF);
      access(16'h2000, 2'b10, 1'b0, 1'b0, 32'd0);
      access(16'h2003, 2'b00, 1'b0, 1'b0, 32'd0);
      access(16'h2003, 2'b00, 1'b0, 1'b1, 32'd0);
      access(16'h2002, 2'b01, 1'b0, 1'b0, 32'd0);
      access(16'h2001, 2'b00, 1'b1, 1'b0, 32'h00000011);
      access(16'h2000, 2'b10, 1'b0, 1'b0, 32'd0);

      // Misaligned store and loads.
      access(16'h2000, 2'b10, 1'b1, 1'b0, 32'd0);
      access(16'h2004, 2'b10, 1'b1, 1'b0, 32'd0);
      access(16'h2001, 2'b10, 1'b1, 1'b0, 32'hAABBCCDD);
      access(16'h2000, 2'b10, 1'b0, 1'b0, 32'd0);
      access(16'h2004, 2'b10, 1'b0, 1'b0, 32'd0);
      access(16'h2001, 2'b10, 1'b0, 1'b0, 32'd0);
      access(16'h2003, 2'b01, 1'b0, 1'b0, 32'd0);
      access(16'h2003, 2'b01, 1'b0, 1'b1, 32'd0);
      access(16'h2003, 2'b11, 1'b0, 1'b0, 32'd0);

      // Window boundaries.
      access(16'h1FFC, 2'b10, 1'b0, 1'b0, 32'd0);
      access(16'h1FFF, 2'b00, 1'b0, 1'b0, 32'd0);
      access(16'h3FFE, 2'b10, 1'b1, 1'b0, 32'h12345678);
      access(16'h3FFC, 2'b10, 1'b0, 1'b0, 32'd0);
      access(16'h3FFF, 2'b00, 1'b1, 1'b0, 32'h000000A5);
      access(16'h3FFF, 2'b00, 1'b0, 1'b0, 32'd0);
      access(16'h3FFE, 2'b01, 1'b0, 1'b1, 32'd0);
      access(16'h3FFF, 2'b01, 1'b0, 1'b0, 32'd0);
      access(16'h4000, 2'b00, 1'b0, 1'b0, 32'd0);

      // Reset during SECOND of a crossing store.
      access(16'h2004, 2'b10, 1'b1, 1'b0, 32'h55667788);
      bus.i_addr = 16'h2003; bus.i_size = 2'b10; bus.i_wren = 1'b1;
      bus.i_unsigned = 1'b0; bus.i_wdata = 32'h44332211; bus.i_req = 1'b1;
      @(negedge clk);
      check("split_first_stall", 32'(bus.o_stall), 32'd1);
      check("split_first_ready", 32'(bus.o_ready), 32'd0);
      @(posedge clk);
      #1;
      check("split_second_ready", 32'(bus.o_ready), 32'd1);
      rst = 1'b0;
      #1;
      check("async_rst_ready", 32'(bus.o_ready), 32'd0);
      check("async_rst_stall", 32'(bus.o_stall), 32'd0);
      check("async_rst_err",   32'(bus.o_err),   32'd0);
      bus.i_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      ref_mem['h2003 - BASE] = 8'h11;  // only the first half was committed
      access(16'h2003, 2'b00, 1'b0, 1'b1, 32'd0);
      access(16'h2004, 2'b10, 1'b0, 1'b0, 32'd0);
      access(16'h2000, 2'b10, 1'b0, 1'b0, 32'd0);

      // Randomised traffic, weighted toward a small region and both edges.
      for (int n = 0; n < 400; n++) begin
         rsel = $urandom_range(0, 9);
         if (rsel == 0)      ra = 16'($urandom_range(32'h1FF8, 32'h2008));
         else if (rsel == 1) ra = 16'($urandom_range(32'h3FF8, 32'h4008));
         else                ra = 16'(BASE + $urandom_range(0, 127));
         access(ra, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom);
      end

      // Second build: window 0x4000..0x43FF.
      bus2.i_addr = 16'h43FC; bus2.i_size = 2'b10; bus2.i_wren = 1'b1;
      bus2.i_wdata = 32'hC0FFEE42; bus2.i_req = 1'b1;
      @(negedge clk);
      check("p2_store_ready", 32'(bus2.o_ready), 32'd1);
      check("p2_store_err",   32'(bus2.o_err),   32'd0);
      check("p2_store_stall", 32'(bus2.o_stall), 32'd0);
      @(posedge clk);
      #1;
      bus2.i_wren = 1'b0;
      @(negedge clk);
      check("p2_load_ready", 32'(bus2.o_ready), 32'd1);
      check("p2_load_rdata", bus2.o_rdata, 32'hC0FFEE42);
      @(posedge clk);
      #1;
      bus2.i_addr = 16'h4400;
      @(negedge clk);
      check("p2_top_err",   32'(bus2.o_err),   32'd1);
      check("p2_top_ready", 32'(bus2.o_ready), 32'd1);
      check("p2_top_rdata", bus2.o_rdata,      32'd0);
      @(posedge clk);
      #1;
      bus2.i_addr = 16'h3FFC;
      @(negedge clk);
      check("p2_below_err", 32'(bus2.o_err), 32'd1);
      @(posedge clk);
      #1;
      bus2.i_req = 1'b0;

      @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_data_mem.md
Name: lsu_data_mem

Overview:
Parametrised data memory for the RV32 core's load/store path. It replaces the fixed 2048-word, word-only data memory.
- Adds byte, halfword and word accesses with sign/zero extension.
- Adds a configurable base address and depth, and range-error reporting.
- A two-cycle state machine splits misaligned accesses that cross a word boundary, stalling the core for one cycle.

Parameters:
ADDR_W, 16, width of the byte address.
BASE_ADDR, 16'h2000, first byte address of the memory window.
DEPTH_WORDS, 2048, number of 32-bit words; must be a power of two.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  asynchronous active-low reset.
i_req  input  1  access request this cycle.
i_wren  input  1  1 = store, 0 = load; qualified by i_req.
i_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
i_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
i_addr  input  ADDR_W  byte address.
i_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
o_rdata  output  32  extended load data; valid when o_ready=1 and the access is a load.
o_ready  output  1  access completes this cycle.
o_stall  output  1  core must hold every input stable next cycle.
o_err  output  1  access out of range; nothing written, o_rdata=0.

Behaviour:
- Storage: DEPTH_WORDS x 4 byte lanes, little-endian. Word index = (i_addr-BASE_ADDR)>>2; offset = i_addr[1:0].
- Contents are not reset. Reset clears only the FSM and the hold register.
- In range: BASE_ADDR <= addr and every accessed byte < BASE_ADDR+4*DEPTH_WORDS.
- Crossing: word at offset 1..3, or half at offset 3. Bytes never cross.
- FSM states: IDLE, SECOND. Reset state is IDLE.
- Reset values: o_rdata=0, o_ready=0, o_stall=0, o_err=0; hold register=0.
- IDLE, i_req=0: all outputs 0; no write.
- IDLE, i_req=1, any byte out of range (including the second word past the top): o_err=1, o_ready=1, o_stall=0, o_rdata=0. No write; stay in IDLE.
- IDLE, i_req=1, non-crossing, in range:
  - o_ready=1 in the same cycle.
  - Load: o_rdata is the combinational read of the addressed bytes, extended.
  - Store: only the addressed byte lanes are written at the next rising edge; other lanes are unchanged.
- IDLE, i_req=1, crossing, in range:
  - o_stall=1, o_ready=0.
  - Store: writes the low-part bytes (offset..3) of word W at the edge.
  - Load: captures bytes offset..3 of word W into the hold register.
  - Next state: SECOND.
- SECOND, with inputs held stable by the core:
  - Accesses word W+1, bytes 0..(offset+size_bytes-5).
  - Store: writes those lanes.
  - Load: o_rdata = {new bytes, hold bytes}, extended.
  - o_ready=1, o_stall=0; next state IDLE.
- i_req dropping to 0 while in SECOND is a protocol error. The block still completes the second half.
- Extension: byte extends from bit 7, half from bit 15; word is unchanged. i_unsigned is ignored for stores.
- A load in the cycle after a store to the same byte sees the new data, because the write commits at the edge.
- Reset asserted in SECOND:
  - The FSM returns to IDLE immediately.
  - The first-half write is already committed and stays; the second half is never written.
  - Outputs go to 0 asynchronously.
- Read port is combinational from the array, so it maps to distributed RAM or an equivalent. The write port is synchronous.

Test Plan:
1. SW 0xDEADBEEF @0x2000, then LW @0x2000 -> o_rdata=0xDEADBEEF, o_ready=1 in one cycle, o_stall=0.
2. Byte/half loads on that word: LB @0x2003 -> 0xFFFFFFDE; LBU @0x2003 -> 0x000000DE; LH @0x2002 -> 0xFFFFDEAD. SB 0x11 @0x2001, then LW @0x2000 -> 0xDEAD11EF.
3. Misaligned store and loads, memory zeroed first:
   - SW 0xAABBCCDD @0x2001 -> cycle 1: o_stall=1; cycle 2: o_ready=1.
   - LW @0x2000 -> 0xBBCCDD00.
   - LW @0x2004 -> 0x000000AA.
   - LW @0x2001 -> stall 1 cycle, then 0xAABBCCDD.
4. Range errors:
   - LW @0x1FFC -> o_err=1, o_rdata=0.
   - SW @0x3FFE -> o_err=1; LW @0x3FFC is unchanged afterwards.
   - SB @0x3FFF -> ok.
5. Reset in SECOND: SW 0x44332211 @0x2003, pull i_rst low during the SECOND cycle.
   - Outputs go to 0 immediately; the FSM returns to IDLE.
   - After release: byte @0x2003=0x11 and word @0x2004 is unchanged.
6. Parameter build with BASE_ADDR=16'h4000, DEPTH_WORDS=256:
   - SW/LW @0x43FC succeeds.
   - Access @0x4400 -> o_err=1.
